// File: rtl/int_ctrl.sv
// int_ctrl: memory-mapped interrupt controller driving the CP0 HWInt lines.
// Synchronises raw IRQs, latches rising edges or follows levels per source,
// tracks overruns, masks with ENABLE and registers the result onto hw_int.
module int_ctrl #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_7F40,
    parameter int unsigned NSRC      = 6
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NSRC-1:0] irq_in,
    input  logic [31:0]     addr,
    input  logic            we,
    input  logic [31:0]     wdata,
    output logic [31:0]     rdata,
    output logic [NSRC-1:0] hw_int
);

    logic [NSRC-1:0] s1, s2, s3;
    logic [NSRC-1:0] rise;
    logic [NSRC-1:0] enable_r, mode_r;
    logic [NSRC-1:0] pend_lat, ovr_r;
    logic [NSRC-1:0] pend_nxt, ovr_nxt;
    logic [NSRC-1:0] pend_eff, active;
    logic [NSRC-1:0] w1c_pend, w1c_ovr;
    logic            hit;
    logic            wr_enable, wr_mode, wr_pend;
    logic [2:0]      st_idx;
    logic            st_valid;
    logic            unused_bits;

    assign unused_bits = ^{addr[1:0], wdata};

    assign hit       = (addr[31:4] == BASE_ADDR[31:4]);
    assign wr_enable = we && hit && (addr[3:2] == 2'd0);
    assign wr_mode   = we && hit && (addr[3:2] == 2'd1);
    assign wr_pend   = we && hit && (addr[3:2] == 2'd2);

    assign rise     = s2 & ~s3;
    assign w1c_pend = wr_pend ? (wdata[NSRC-1:0] & mode_r) : '0;
    assign w1c_ovr  = wr_pend ? wdata[8 +: NSRC] : '0;

    // Edge-mode sources report the latched bit, level-mode sources the synchronised line
    assign pend_eff = (pend_lat & mode_r) | (s2 & ~mode_r);
    assign active   = pend_eff & enable_r;

    // Synchroniser chain plus the one-cycle delayed copy used for edge detection
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1 <= '0;
            s2 <= '0;
            s3 <= '0;
        end else begin
            s1 <= irq_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    // Next pending/overrun state: a new edge always beats a same-cycle clear
    always_comb begin
        pend_nxt = '0;
        ovr_nxt  = '0;
        for (int unsigned i = 0; i < NSRC; i++) begin
            if (wr_mode && !wdata[i]) begin
                pend_nxt[i] = 1'b0;
                ovr_nxt[i]  = 1'b0;
            end else if (mode_r[i]) begin
                pend_nxt[i] = rise[i] | (pend_lat[i] & ~w1c_pend[i]);
                ovr_nxt[i]  = (rise[i] & pend_lat[i]) | (ovr_r[i] & ~w1c_ovr[i]);
            end else begin
                pend_nxt[i] = 1'b0;
                ovr_nxt[i]  = 1'b0;
            end
        end
    end

    // Control registers, latched pending/overrun state and the registered HWInt
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            enable_r <= '0;
            mode_r   <= '0;
            pend_lat <= '0;
            ovr_r    <= '0;
            hw_int   <= '0;
        end else begin
            if (wr_enable) enable_r <= wdata[NSRC-1:0];
            if (wr_mode)   mode_r   <= wdata[NSRC-1:0];
            pend_lat <= pend_nxt;
            ovr_r    <= ovr_nxt;
            hw_int   <= active;
        end
    end

    // Lowest-index active source wins the STATUS report
    always_comb begin
        st_idx   = '0;
        st_valid = 1'b0;
        for (int unsigned i = NSRC; i > 0; i--) begin
            if (active[i-1]) begin
                st_idx   = 3'(i - 1);
                st_valid = 1'b1;
            end
        end
    end

    // Combinational read mux; misses and unused bits read zero
    always_comb begin
        rdata = '0;
        if (hit) begin
            case (addr[3:2])
                2'd0: rdata[NSRC-1:0] = enable_r;
                2'd1: rdata[NSRC-1:0] = mode_r;
                2'd2: begin
                    rdata[NSRC-1:0]  = pend_eff;
                    rdata[8 +: NSRC] = ovr_r;
                end
                default: begin
                    rdata[31]  = st_valid;
                    rdata[2:0] = st_idx;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_int_ctrl.sv
// tb_int_ctrl: directed stimulus with a scoreboard queue; the monitor checks
// every queued expectation at the falling clock edge.
module tb_int_ctrl;

  localparam logic [31:0] B = 32'h0000_7F40;

  logic        clk;
  logic        reset;
  logic [5:0]  irq_in;
  logic [31:0] addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [5:0]  hw_int;
  logic        done;

  typedef struct {
    string       name;
    bit          is_rd;
    logic [31:0] exp;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  int_ctrl #(.BASE_ADDR(B), .NSRC(6)) dut (
    .clk    (clk),
    .reset  (reset),
    .irq_in (irq_in),
    .addr   (addr),
    .we     (we),
    .wdata  (wdata),
    .rdata  (rdata),
    .hw_int (hw_int)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    exp_t        it;
    logic [31:0] act;
    while (exp_q.size() > 0) begin
      it  = exp_q.pop_front();
      act = it.is_rd ? rdata : {26'b0, hw_int};
      total++;
      if (act !== it.exp) begin
        bad++;
        $display("FAIL %s: got 0x%08h expected 0x%08h", it.name, act, it.exp);
      end
    end
  end

  initial begin
    done = 1'b0;
    #200000;
    if (!done) begin
      total++;
      bad++;
      $display("FAIL timeout: sequence did not complete within the wait bound");
      $display("test done: total=%0d bad=%0d", total, bad);
      $display("TEST FAILED");
      $finish;
    end
  end

  task automatic chk_now(input logic [5:0] ehw, input logic [31:0] erd, input string n);
    total++;
    if (hw_int !== ehw || rdata !== erd) begin
      bad++;
      $display("FAIL %s: hw_int=0x%02h rdata=0x%08h expected hw_int=0x%02h rdata=0x%08h",
               n, hw_int, rdata, ehw, erd);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    we    = 1'b1;
    tick();
    we    = 1'b0;
  endtask

  task automatic exp_rd(input logic [31:0] a, input logic [31:0] e, input string n);
    exp_t it;
    addr     = a;
    it.name  = n;
    it.is_rd = 1'b1;
    it.exp   = e;
    exp_q.push_back(it);
    tick();
  endtask

  task automatic exp_hw(input logic [5:0] e, input string n);
    exp_t it;
    it.name  = n;
    it.is_rd = 1'b0;
    it.exp   = {26'b0, e};
    exp_q.push_back(it);
  endtask

  task automatic pulse(input logic [5:0] m);
    irq_in = m;
    tick();
    irq_in = '0;
  endtask

  initial begin
    reset  = 1'b0;
    irq_in = '0;
    addr   = '0;
    we     = 1'b0;
    wdata  = '0;
    tick();
    tick();
    addr = B + 8;
    #1;
    chk_now(6'h00, 32'h0, "rst_direct");
    exp_hw(6'h00, "rst_hw");
    exp_rd(B + 8, 32'h0, "rst_pend");
    reset = 1'b1;
    tick();

    // 1) edge pulse on bit 0, latency, W1C
    wr(B, 32'h3F);
    wr(B + 4, 32'h01);
    pulse(6'h01);
    tick();
    tick();
    exp_hw(6'h00, "t1_e3");
    tick();
    exp_hw(6'h01, "t1_e4");
    tick();
    exp_hw(6'h01, "t1_hold");
    exp_rd(B + 8, 32'h01, "t1_pend");
    wr(B + 8, 32'h01);
    exp_hw(6'h01, "t1_w1c_same");
    tick();
    exp_hw(6'h00, "t1_w1c_next");

    // 2) level mode on bit 2, W1C has no effect
    wr(B + 4, 32'h00);
    wr(B, 32'h04);
    irq_in = 6'h04;
    repeat (5) tick();
    wr(B + 8, 32'h04);
    exp_hw(6'h04, "t2_lvl");
    exp_rd(B + 8, 32'h04, "t2_w1c_noeff");
    repeat (3) tick();
    irq_in = '0;
    repeat (5) tick();
    exp_hw(6'h00, "t2_drop");

    // 3) overrun on bit 1
    wr(B, 32'h3F);
    wr(B + 4, 32'h02);
    pulse(6'h02);
    repeat (4) tick();
    pulse(6'h02);
    repeat (4) tick();
    exp_rd(B + 8, 32'h202, "t3_ovr");
    wr(B + 8, 32'h200);
    exp_rd(B + 8, 32'h002, "t3_ovr_clr");
    exp_hw(6'h02, "t3_hw");

    // 4) rise on bit 3 in the same cycle as its W1C
    wr(B + 8, 32'h02);
    wr(B + 4, 32'h0A);
    pulse(6'h08);
    repeat (4) tick();
    exp_rd(B + 8, 32'h08, "t4_pre");
    pulse(6'h08);
    tick();
    wr(B + 8, 32'h08);
    tick();
    exp_hw(6'h08, "t4_hw");
    exp_rd(B + 8, 32'h808, "t4_pend_ovr");

    // 5) STATUS priority and masking
    wr(B + 8, 32'h800);
    wr(B + 4, 32'h28);
    pulse(6'h20);
    repeat (4) tick();
    exp_rd(B + 8, 32'h28, "t5_pend");
    exp_rd(B + 12, 32'h8000_0003, "t5_st_all");
    wr(B, 32'h20);
    exp_rd(B + 12, 32'h8000_0005, "t5_st_en20");
    wr(B, 32'h00);
    exp_hw(6'h20, "t5_hw_old");
    exp_rd(B + 12, 32'h0, "t5_st_none");
    exp_hw(6'h00, "t5_hw_off");

    // 6) asynchronous reset mid-operation, then window misses
    wr(B + 4, 32'h3F);
    wr(B, 32'h3F);
    pulse(6'h3F);
    repeat (4) tick();
    exp_hw(6'h3F, "t6_hw_all");
    exp_rd(B + 12, 32'h8000_0000, "t6_st_idx0");
    addr  = B + 8;
    reset = 1'b0;
    #1;
    chk_now(6'h00, 32'h0, "t6_rst_direct");
    exp_hw(6'h00, "t6_rst_hw");
    begin
      exp_t it;
      it.name  = "t6_rst_pend";
      it.is_rd = 1'b1;
      it.exp   = 32'h0;
      exp_q.push_back(it);
    end
    @(negedge clk);
    tick();
    reset = 1'b1;
    tick();
    wr(32'h0000_7F50, 32'h3F);
    exp_rd(32'h0000_7F50, 32'h0, "t6_miss_rd");
    exp_rd(B, 32'h0, "t6_miss_wr");
    wr(B + 12, 32'hFFFF_FFFF);
    exp_rd(B + 12, 32'h0, "t6_st_ro");

    @(negedge clk);
    #1;
    done = 1'b1;
    $display("test done: total=%0d bad=%0d", total, bad);
    if (bad == 0 && total > 0)
      $display("TEST PASSED");
    else
      $display("TEST FAILED");
    $finish;
  end

endmodule
